regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between NREQ writeback requesters (ALU, load unit, debug/host) using round-robin arbitration with a valid/ready handshake.
- Contains a clear sequencer that zero-fills every register after reset and on command, so the register file needs no reset logic of its own.
- Sits between the writeback stage and the register file write port (write enable, address, data).

Parameters:
- NREQ, 3, number of write requesters (2..8).
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*ADDR_W  flattened destination addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  flattened write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  one-hot grant; combinational.
- clear_start  input  1  single-cycle pulse requesting a zero-fill sweep.
- busy  output  1  high while a sweep is in progress.
- clear_done  output  1  one-cycle pulse after the final sweep write.
- rf_we  output  1  register file write enable (registered).
- rf_waddr  output  ADDR_W  register file write address (registered).
- rf_wdata  output  DATA_W  register file write data (registered).

Behaviour:
- States: CLEAR, ARB.
- Reset (asserted): state=CLEAR, clr_idx=0, rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, clear_done=0.
  - Because state=CLEAR during reset, busy=1 and req_ready=0 for as long as reset is asserted.
- CLEAR state, each cycle:
  - Registers rf_we=1, rf_waddr=clr_idx, rf_wdata=0; then clr_idx++.
  - When clr_idx==DEPTH-1, transition to ARB and register clear_done=1 in the same cycle; clear_done is visible for the first cycle in ARB.
  - A sweep is exactly DEPTH consecutive writes to addresses 0..DEPTH-1.
  - busy=(state==CLEAR); req_ready=0 throughout.
  - clear_start is ignored during CLEAR (no restart).
- ARB state, grant logic:
  - Search starts at rr_ptr and wraps modulo NREQ; the first requester with req_valid=1 gets req_ready=1.
  - At most one ready bit is high.
  - All ready bits are 0 when clear_start=1.
- ARB state, transfer (req_valid[i] & req_ready[i]):
  - Registers rf_waddr=addr_i and rf_wdata=data_i.
  - rf_we=1 if addr_i!=0; rf_we=0 if addr_i==0 (the write is accepted and dropped, so register 0 is never written by requesters).
  - rr_ptr=(i+1) mod NREQ.
- ARB state, no transfer: rf_we=0; rf_waddr and rf_wdata hold their values; rr_ptr holds.
- clear_start in ARB: next state CLEAR with clr_idx=0; no grant in that cycle; rf_we=0 in that cycle.
- Latency: handshake in cycle N → rf_we/addr/data valid in cycle N+1 → register file updated at the end of N+1.
- Requester contract: hold req_valid, req_addr and req_data stable until ready is seen.
  - The arbiter does not check this; a violation is the requester's bug.
- Fairness: under continuous requests from all NREQ requesters, each is granted exactly once per NREQ cycles.
- Reset mid-sweep: the sweep restarts from address 0 after reset_n deasserts.
- Reset mid-transfer: any pending registered write is discarded (rf_we=0).

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined, adds:
  - Input stat_sel [$clog2(NREQ)-1:0].
  - Output stat_cnt [15:0].
  - Input stat_clr [1], synchronous.
  - One 16-bit grant counter per requester, incremented on each transfer, saturating at 16'hFFFF.
  - Counters are zeroed by reset and by stat_clr; stat_clr takes priority over an increment in the same cycle.
  - stat_cnt = counter[stat_sel], combinational.
  - Sweep writes are not counted.
- When undefined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Reset sweep: deassert reset_n → 32 cycles of rf_we=1 with rf_waddr 0..31 and rf_wdata=0; clear_done pulses once; busy falls; req_ready stays 0 throughout the sweep.
- Single requester: req1 writes addr 5, data 32'hDEADBEEF → ready1 in the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF; register 5 reads back DEADBEEF.
- Round-robin: req0/1/2 all valid and held for 6 cycles with rr_ptr=0 → grant order 0,1,2,0,1,2; no ready bit is ever high for more than one requester.
- Register 0 drop: req0 writes addr 0, data 32'h1234 → ready0=1; next cycle rf_we=0; register 0 reads 0.
- Clear mid-traffic: clear_start pulses while req2 is valid → req_ready=0 that cycle; 32-write sweep follows; req2 is granted on the first cycle after the sweep completes.
- Reset mid-sweep: assert reset_n low at sweep address 17 → after release the sweep restarts at 0. With REGFILE_ARB_STATS_EN defined: 3 grants to req1 → stat_sel=1 gives stat_cnt=3; stat_clr=1 → 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: round-robin writeback arbitration plus zero-fill sweep.
// Ports: clk, reset_n (async, active-low); req_valid/req_addr/req_data in, req_ready out
//   (one-hot, combinational); clear_start in; busy, clear_done out; rf_we/rf_waddr/rf_wdata
//   out (registered). Optional REGFILE_ARB_STATS_EN adds stat_sel, stat_clr, stat_cnt.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clear_start,
    output logic                     busy,
    output logic                     clear_done,
`ifdef REGFILE_ARB_STATS_EN
    input  logic [$clog2(NREQ)-1:0]  stat_sel,
    input  logic                     stat_clr,
    output logic [15:0]              stat_cnt,
`endif
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   clr_idx, clr_idx_n;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
    logic                rf_we_n;
    logic [ADDR_W-1:0]   rf_waddr_n;
    logic [DATA_W-1:0]   rf_wdata_n;
    logic                clear_done_n;

    logic                found;
    logic [PTR_W-1:0]    gidx;
    int                  j;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Rotating priority search starting at rr_ptr; first valid wins.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        gidx      = '0;
        j         = 0;
        if (state == ARB && !clear_start) begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= NREQ) j = j - NREQ;
                if (!found && req_valid[j]) begin
                    found        = 1'b1;
                    req_ready[j] = 1'b1;
                    gidx         = PTR_W'(j);
                end
            end
        end
    end

    assign sel_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(gidx)*DATA_W +: DATA_W];
    assign busy     = (state == CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            rr_ptr     <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            clr_idx    <= clr_idx_n;
            rr_ptr     <= rr_ptr_n;
            rf_we      <= rf_we_n;
            rf_waddr   <= rf_waddr_n;
            rf_wdata   <= rf_wdata_n;
            clear_done <= clear_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        clr_idx_n    = clr_idx;
        rr_ptr_n     = rr_ptr;
        rf_we_n      = 1'b0;
        rf_waddr_n   = rf_waddr;
        rf_wdata_n   = rf_wdata;
        clear_done_n = 1'b0;
        unique case (state)
            CLEAR: begin
                rf_we_n    = 1'b1;
                rf_waddr_n = clr_idx;
                rf_wdata_n = '0;
                clr_idx_n  = clr_idx + 1'b1;
                if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                    state_n      = ARB;
                    clear_done_n = 1'b1;
                    clr_idx_n    = '0;
                end
            end
            ARB: begin
                if (clear_start) begin
                    state_n   = CLEAR;
                    clr_idx_n = '0;
                end else if (found) begin
                    // Writes to register 0 are accepted but never performed.
                    rf_we_n    = (sel_addr != '0);
                    rf_waddr_n = sel_addr;
                    rf_wdata_n = sel_data;
                    if (int'(gidx) == NREQ - 1) rr_ptr_n = '0;
                    else                        rr_ptr_n = gidx + 1'b1;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] cnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else if (found && cnt[gidx] != 16'hFFFF) begin
            cnt[gidx] <= cnt[gidx] + 16'd1;
        end
    end

    assign stat_cnt = (int'(stat_sel) < NREQ) ? cnt[stat_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: sweep, grants, round-robin, r0 drop,
// clear mid-traffic, reset mid-sweep and optional grant counters.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                   clk;
    logic                   reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   clear_start;
    logic                   busy;
    logic                   clear_done;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
`ifdef REGFILE_ARB_STATS_EN
    logic [1:0]             stat_sel;
    logic                   stat_clr;
    logic [15:0]            stat_cnt;
`endif

    int tests;
    int fails;

    logic [DATA_W-1:0] mem [32];

    regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
`ifdef REGFILE_ARB_STATS_EN
        .stat_sel    (stat_sel),
        .stat_clr    (stat_clr),
        .stat_cnt    (stat_cnt),
`endif
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file fed by the write port.
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;
`ifdef REGFILE_ARB_STATS_EN
        stat_sel    = '0;
        stat_clr    = 1'b0;
`endif
        step();
        step();
        req_valid = 3'b111;
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_done", 64'(clear_done), 64'd0);
        req_valid = '0;
        reset_n   = 1'b1;

        // Reset sweep: 32 zero writes, done with the last one.
        for (int i = 0; i < 32; i++) begin
            step();
            chk("sw_we", 64'(rf_we), 64'd1);
            chk("sw_addr", 64'(rf_waddr), 64'(i));
            chk("sw_data", 64'(rf_wdata), 64'd0);
            chk("sw_done", 64'(clear_done), 64'(i == 31));
            chk("sw_busy", 64'(busy), 64'(i != 31));
            if (i < 31) begin
                req_valid = 3'b111;
                #1;
                chk("sw_ready", 64'(req_ready), 64'd0);
                req_valid = '0;
            end
        end
        step();
        chk("sw_done_once", 64'(clear_done), 64'd0);
        chk("sw_we_off", 64'(rf_we), 64'd0);

        // Single requester 1.
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        chk("s1_ready", 64'(req_ready), 64'b010);
        step();
        req_valid = '0;
        chk("s1_we", 64'(rf_we), 64'd1);
        chk("s1_addr", 64'(rf_waddr), 64'd5);
        chk("s1_data", 64'(rf_wdata), 64'hDEADBEEF);
        step();
        chk("s1_we_off", 64'(rf_we), 64'd0);
        chk("s1_mem", 64'(mem[5]), 64'hDEADBEEF);

        // req2 alone: pointer now at 2, brings it back to 0.
        set_req(2, 5'd7, 32'h77);
        req_valid = 3'b100;
        #1;
        chk("s2_ready", 64'(req_ready), 64'b100);
        step();
        req_valid = '0;
        chk("s2_addr", 64'(rf_waddr), 64'd7);
        step();

        // Round-robin with all three held valid.
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hA1);
        set_req(2, 5'd3, 32'hA2);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), 64'(1 << (k % 3)));
            step();
            chk("rr_we", 64'(rf_we), 64'd1);
            chk("rr_addr", 64'(rf_waddr), 64'(k % 3 + 1));
            chk("rr_data", 64'(rf_wdata), 64'(32'hA0 + k % 3));
        end
        req_valid = '0;
        step();

        // Register 0 write is dropped.
        set_req(0, 5'd0, 32'h1234);
        req_valid = 3'b001;
        #1;
        chk("r0_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        chk("r0_we", 64'(rf_we), 64'd0);
        step();
        chk("r0_mem", 64'(mem[0]), 64'd0);

        // Clear while req2 waits; req2 served right after sweep.
        set_req(2, 5'd9, 32'hAA);
        req_valid   = 3'b100;
        clear_start = 1'b1;
        #1;
        chk("cl_ready", 64'(req_ready), 64'd0);
        step();
        clear_start = 1'b0;
        chk("cl_we", 64'(rf_we), 64'd0);
        chk("cl_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 32; i++) begin
            chk("cl_sw_ready", 64'(req_ready), 64'd0);
            step();
            chk("cl_sw_addr", 64'(rf_waddr), 64'(i));
            chk("cl_sw_we", 64'(rf_we), 64'd1);
        end
        chk("cl_done", 64'(clear_done), 64'd1);
        chk("cl_busy_lo", 64'(busy), 64'd0);
        chk("cl_grant", 64'(req_ready), 64'b100);
        step();
        req_valid = '0;
        chk("cl_w_addr", 64'(rf_waddr), 64'd9);
        chk("cl_w_data", 64'(rf_wdata), 64'hAA);
        chk("cl_w_we", 64'(rf_we), 64'd1);

        // Reset at sweep address 17; clear_start ignored mid-sweep.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            clear_start = (i == 5);
            step();
            chk("rs_addr", 64'(rf_waddr), 64'(i));
        end
        clear_start = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rs_we", 64'(rf_we), 64'd0);
        chk("rs_busy", 64'(busy), 64'd1);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("rs_sw_addr", 64'(rf_waddr), 64'(i));
            chk("rs_sw_done", 64'(clear_done), 64'(i == 31));
        end

`ifdef REGFILE_ARB_STATS_EN
        set_req(1, 5'd4, 32'h44);
        req_valid = 3'b010;
        for (int k = 0; k < 3; k++) step();
        req_valid = '0;
        stat_sel  = 2'd1;
        #1;
        chk("st_cnt1", 64'(stat_cnt), 64'd3);
        stat_sel = 2'd0;
        #1;
        chk("st_cnt0", 64'(stat_cnt), 64'd0);
        stat_sel = 2'd1;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("st_clr", 64'(stat_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
